// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer and instruction memory.
// The sequencer (master) publishes the fetch address and request.
// Instruction memory (slave) answers with a ready/accept strobe.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              fetch_valid;
   logic              imem_ready;

   modport master (
      output pc,
      output pc_plus4,
      output fetch_valid,
      input  imem_ready
   );

   modport slave (
      input  pc,
      input  pc_plus4,
      input  fetch_valid,
      output imem_ready
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer for the processor front end.
// It picks the next PC from the sequential path, a branch target, or an
// immediate or register jump target. It also runs the fetch handshake,
// stall holds, the post-redirect flush window and halt/resume.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   Defined:   a redirect to a target with nonzero low bits loads the raw
//              target, sets the sticky misalign_err output and parks in HALT.
//   Undefined: target low bits are cleared before loading, and there is no
//              misalign_err port.
module pc_sequencer #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int                FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   pc_sequencer_if.master     fetch,
   input  logic [1:0]         NextInstrSel,
   input  logic [1:0]         JMPSel,
   input  logic [ADDR_W-1:0]  AddressB,
   input  logic [ADDR_W-1:0]  AddressI,
   input  logic [ADDR_W-1:0]  AddressR,
   input  logic               stall,
   input  logic               halt,
   input  logic               resume,
   output logic               flush,
   output logic [1:0]         state
`ifdef MISALIGN_TRAP_EN
   ,
   output logic               misalign_err
`endif
);

   // The flush counter only needs to hold FLUSH_CYCLES-1.
   // It is kept at least one bit wide so that it exists even when there is no flush window.
   localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] FLUSH_LOAD =
      (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10,
      HALT  = 2'b11
   } state_t;

   state_t            cur_state;
   state_t            next_state;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_next;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_next;
   logic              redirect;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] aligned_target;
`ifdef MISALIGN_TRAP_EN
   logic              err_q;
   logic              err_next;
`endif

   // Decode the PC decoder's select into a redirect request and its target address.
   always_comb begin
      redirect = 1'b0;
      target   = '0;
      case (NextInstrSel)
         2'b11: begin
            redirect = 1'b1;
            target   = AddressB;
         end
         2'b01: begin
            if (JMPSel == 2'b01) begin
               redirect = 1'b1;
               target   = AddressI;
            end else if (JMPSel == 2'b10) begin
               redirect = 1'b1;
               target   = AddressR;
            end
         end
         default: begin
            redirect = 1'b0;
            target   = '0;
         end
      endcase
   end

   assign aligned_target = target & ~ADDR_W'(3);

   // Next-state, next-PC and flush-counter logic for the sequencing FSM.
   always_comb begin
      next_state = cur_state;
      pc_next    = pc_q;
      cnt_next   = cnt_q;
`ifdef MISALIGN_TRAP_EN
      err_next   = err_q;
`endif
      case (cur_state)
         IDLE: begin
            next_state = RUN;
         end
         RUN: begin
            if (redirect) begin
`ifdef MISALIGN_TRAP_EN
               if (target[1:0] != 2'b00) begin
                  pc_next    = target;
                  err_next   = 1'b1;
                  next_state = HALT;
               end else
`endif
               begin
                  pc_next = aligned_target;
                  if (FLUSH_CYCLES > 0) begin
                     next_state = FLUSH;
                     cnt_next   = FLUSH_LOAD;
                  end
               end
            end else if (halt) begin
               next_state = HALT;
            end else if (fetch.imem_ready && !stall) begin
               pc_next = pc_q + ADDR_W'(4);
            end
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               next_state = RUN;
            end else begin
               cnt_next = cnt_q - CNT_W'(1);
            end
         end
         HALT: begin
            if (resume) begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, PC and flush-counter registers. Reset acts immediately from any state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state <= IDLE;
         pc_q      <= RESET_PC;
         cnt_q     <= '0;
`ifdef MISALIGN_TRAP_EN
         err_q     <= 1'b0;
`endif
      end else begin
         cur_state <= next_state;
         pc_q      <= pc_next;
         cnt_q     <= cnt_next;
`ifdef MISALIGN_TRAP_EN
         err_q     <= err_next;
`endif
      end
   end

   assign fetch.pc          = pc_q;
   assign fetch.pc_plus4    = pc_q + ADDR_W'(4);
   assign fetch.fetch_valid = (cur_state == RUN);
   assign flush             = (cur_state == FLUSH);
   assign state             = cur_state;
`ifdef MISALIGN_TRAP_EN
   assign misalign_err      = err_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// A reference model predicts the outputs after each clock edge and queues them.
// The DUT outputs are then popped from that queue and compared one cycle at a time.
module tb_pc_sequencer;

   localparam int          ADDR_W       = 32;
   localparam logic [31:0] RESET_PC     = 32'h0;
   localparam int          FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  next_instr_sel;
   logic [1:0]  jmp_sel;
   logic [31:0] address_b;
   logic [31:0] address_i;
   logic [31:0] address_r;
   logic        stall;
   logic        halt;
   logic        resume;
   logic        flush;
   logic [1:0]  state;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   pc_sequencer_if #(.ADDR_W(ADDR_W)) fetch_bus ();

   pc_sequencer #(
      .ADDR_W       (ADDR_W),
      .RESET_PC     (RESET_PC),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch        (fetch_bus),
      .NextInstrSel (next_instr_sel),
      .JMPSel       (jmp_sel),
      .AddressB     (address_b),
      .AddressI     (address_i),
      .AddressR     (address_r),
      .stall        (stall),
      .halt         (halt),
      .resume       (resume),
      .flush        (flush),
      .state        (state)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign_err (misalign_err)
`endif
   );

   // Free-running clock with a 10 time-unit period.
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  st;
      logic        fv;
      logic        fl;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks_total  = 0;
   int   checks_passed = 0;

   logic [31:0] m_pc;
   logic [1:0]  m_state;
   int          m_cnt;
   logic        m_err;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks_total++;
      if (observed === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_pc    = RESET_PC;
      m_state = 2'b00;
      m_cnt   = 0;
      m_err   = 1'b0;
   endtask

   task automatic modelStep(input logic [1:0] sel, input logic [1:0] jmp,
                            input logic [31:0] ab, input logic [31:0] ai,
                            input logic [31:0] ar, input logic stl,
                            input logic hlt, input logic res, input logic rdy);
      logic        redir;
      logic [31:0] tgt;
      redir = 1'b0;
      tgt   = 32'h0;
      case (m_state)
         2'b00: m_state = 2'b01;
         2'b01: begin
            if (sel == 2'b11) begin
               redir = 1'b1;
               tgt   = ab;
            end else if (sel == 2'b01 && jmp == 2'b01) begin
               redir = 1'b1;
               tgt   = ai;
            end else if (sel == 2'b01 && jmp == 2'b10) begin
               redir = 1'b1;
               tgt   = ar;
            end
            if (redir) begin
`ifdef MISALIGN_TRAP_EN
               if (tgt[1:0] != 2'b00) begin
                  m_pc    = tgt;
                  m_err   = 1'b1;
                  m_state = 2'b11;
               end else
`endif
               begin
                  m_pc = {tgt[31:2], 2'b00};
                  if (FLUSH_CYCLES > 0) begin
                     m_state = 2'b10;
                     m_cnt   = FLUSH_CYCLES - 1;
                  end
               end
            end else if (hlt) begin
               m_state = 2'b11;
            end else if (rdy && !stl) begin
               m_pc = m_pc + 32'd4;
            end
         end
         2'b10: begin
            if (m_cnt == 0) m_state = 2'b01;
            else m_cnt = m_cnt - 1;
         end
         default: begin
            if (res) m_state = 2'b01;
         end
      endcase
   endtask

   task automatic pushExpected();
      exp_t e;
      e.pc  = m_pc;
      e.st  = m_state;
      e.fv  = (m_state == 2'b01);
      e.fl  = (m_state == 2'b10);
      e.err = m_err;
      exp_q.push_back(e);
   endtask

   task automatic popAndCheck(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         checkOutput({tag, ".pc"}, fetch_bus.pc, e.pc);
         checkOutput({tag, ".pc_plus4"}, fetch_bus.pc_plus4, e.pc + 32'd4);
         checkOutput({tag, ".state"}, {30'd0, state}, {30'd0, e.st});
         checkOutput({tag, ".fetch_valid"}, {31'd0, fetch_bus.fetch_valid}, {31'd0, e.fv});
         checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
`ifdef MISALIGN_TRAP_EN
         checkOutput({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e.err});
`endif
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [1:0] sel,
                                input logic [1:0] jmp, input logic [31:0] ab,
                                input logic [31:0] ai, input logic [31:0] ar,
                                input logic stl, input logic hlt,
                                input logic res, input logic rdy);
      @(negedge clk);
      next_instr_sel       = sel;
      jmp_sel              = jmp;
      address_b            = ab;
      address_i            = ai;
      address_r            = ar;
      stall                = stl;
      halt                 = hlt;
      resume               = res;
      fetch_bus.imem_ready = rdy;
      modelStep(sel, jmp, ab, ai, ar, stl, hlt, res, rdy);
      pushExpected();
      @(posedge clk);
      #1;
      popAndCheck(tag);
   endtask

   task automatic stepSeq(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(tag, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic releaseReset(input string tag);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pushExpected();
      #1;
      popAndCheck(tag);
   endtask

   task automatic applyReset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b0;
      modelReset();
      pushExpected();
      #1;
      popAndCheck(tag);
      releaseReset({tag, "_release"});
   endtask

   // Bound the run so a broken design can never hang the simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence covering the sequencing scenarios.
   initial begin
      rst                  = 1'b0;
      next_instr_sel       = 2'b00;
      jmp_sel              = 2'b00;
      address_b            = 32'h0;
      address_i            = 32'h0;
      address_r            = 32'h0;
      stall                = 1'b0;
      halt                 = 1'b0;
      resume               = 1'b0;
      fetch_bus.imem_ready = 1'b1;
      modelReset();
      #3;
      pushExpected();
      popAndCheck("reset");
      releaseReset("idle_after_release");

      applyStimulus("idle_to_run", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      stepSeq("seq", 4);

      for (int i = 0; i < 3; i++)
         applyStimulus("stall_hold", 2'b00, 2'b00, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      stepSeq("after_stall", 1);
      for (int i = 0; i < 2; i++)
         applyStimulus("not_ready_hold", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepSeq("after_not_ready", 1);

      applyStimulus("branch_with_stall", 2'b11, 2'b00, 32'h100, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++)
         applyStimulus("flush_ignores_inputs", 2'b11, 2'b00, 32'h900, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      stepSeq("after_branch", 2);

      applyStimulus("jump_reg_misaligned", 2'b01, 2'b10, 0, 0, 32'h203, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         applyStimulus("after_jump_reg", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

      applyStimulus("reserved_sel", 2'b10, 2'b00, 32'h500, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("bad_jmpsel_11", 2'b01, 2'b11, 0, 32'h600, 32'h700, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus("bad_jmpsel_00", 2'b01, 2'b00, 0, 32'h600, 32'h700, 1'b0, 1'b0, 1'b0, 1'b1);

      applyStimulus("jump_imm_with_halt", 2'b01, 2'b01, 0, 32'h40, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      stepSeq("flush_40", 2);
      applyStimulus("halt_at_40", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus("halt_held", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus("halt_resume_same", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      stepSeq("after_resume", 1);

      applyStimulus("halt_and_stall", 2'b00, 2'b00, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus("resume2", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      stepSeq("after_resume2", 1);

      applyStimulus("branch_not_ready", 2'b11, 2'b00, 32'h80, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepSeq("flush_80", 3);

      applyStimulus("branch_300", 2'b11, 2'b00, 32'h300, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyReset("reset_in_flush");
      stepSeq("restart", 2);

      applyStimulus("jump_top", 2'b01, 2'b01, 0, 32'hFFFF_FFFC, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      stepSeq("flush_top", 2);
      stepSeq("wrap", 2);

      if (exp_q.size() != 0)
         checkOutput("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
